seq_div_unit: RTL and testbench



---
 rtl/seq_div_unit.sv | 136 +++++++++++++
 tb/tb_seq_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_div_unit.sv
// Restoring unsigned divider: one quotient bit per clock behind a start/done handshake.
// Divide-by-zero completes immediately with Q = all ones, R = X and dz set.
`timescale 1ns/1ps
module seq_div_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             dz
);

    localparam int unsigned AW    = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [AW-1:0]      a_q, a_d;
    logic [WIDTH-1:0]   wq_q, wq_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               dz_q, dz_d;

    logic [AW+WIDTH-1:0] shift_c;
    logic [AW-1:0]       trial_c;
    logic                fits_c;

    // Shifted partial remainder and the trial subtraction for this iteration.
    always_comb begin
        shift_c = {a_q, wq_q} << 1;
        trial_c = shift_c[AW+WIDTH-1:WIDTH] - {1'b0, y_q};
        fits_c  = ~trial_c[AW-1];
    end

    // Next-state and datapath; results only load on the edge that enters DONE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        wq_d    = wq_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    y_d     = Y;
                    a_d     = '0;
                    wq_d    = X;
                    count_d = CNT_W'(WIDTH);
                    if (Y == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        q_d     = '1;
                        r_d     = X;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                a_d     = fits_c ? trial_c : shift_c[AW+WIDTH-1:WIDTH];
                wq_d    = shift_c[WIDTH-1:0] | WIDTH'(fits_c);
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = wq_d;
                    r_d     = a_d[WIDTH-1:0];
                    dz_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            a_q     <= '0;
            wq_q    <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            wq_q    <= wq_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed checks of seq_div_unit: results, latency, divide-by-zero, ignored start,
// back-to-back operation and asynchronous reset.
`timescale 1ns/1ps
module tb_seq_div_unit;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;

    int n_pass;
    int n_tot;

    seq_div_unit #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (x),
        .Y     (y),
        .busy  (busy),
        .done  (done),
        .Q     (q),
        .R     (r),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Issue one operation with a single-cycle start and check result and timing.
    task automatic run_op(input logic [WIDTH-1:0] xi, input logic [WIDTH-1:0] yi,
                          input int eq, input int er, input int edz, input int elat);
        int n;
        int nb;
        @(negedge clk);
        x = xi; y = yi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(elat));
        check("busy_cycles", 32'(nb), 32'(elat));
        check("busy_at_done", 32'(busy), 32'd0);
        check("q", 32'(q), 32'(eq));
        check("r", 32'(r), 32'(er));
        check("dz", 32'(dz), 32'(edz));
        @(negedge clk);
        check("done_pulse_end", 32'(done), 32'd0);
    endtask

    initial begin
        int pulses;
        int pos;
        int qs;
        int rs;
        n_pass = 0; n_tot = 0;
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_dz", 32'(dz), 32'd0);
        rst_n = 1'b1;

        run_op(4'd13, 4'd4, 3, 1, 0, 4);
        repeat (5) @(negedge clk);
        check("hold_q", 32'(q), 32'd3);
        check("hold_r", 32'(r), 32'd1);

        run_op(4'd15, 4'd1, 15, 0, 0, 4);
        run_op(4'd3,  4'd7, 0, 3, 0, 4);
        run_op(4'd0,  4'd5, 0, 0, 0, 4);
        run_op(4'd9,  4'd0, 15, 9, 1, 0);
        run_op(4'd8,  4'd2, 4, 0, 0, 4);

        // start during RUN must be ignored
        @(negedge clk);
        x = 4'd12; y = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; pos = -1; qs = 0; rs = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin x = 4'd1; y = 4'd1; start = 1'b1; end
            if (i == 3) start = 1'b0;
            if (done) begin pulses++; pos = i; qs = 32'(q); rs = 32'(r); end
            @(negedge clk);
        end
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_pos", 32'(pos), 32'd4);
        check("ign_q", 32'(qs), 32'd2);
        check("ign_r", 32'(rs), 32'd2);

        // start held high: a new operation every 5 cycles
        x = 4'd14; y = 4'd3; start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("bb_pos", 32'(i % 5), 32'd4);
                check("bb_q", 32'(q), 32'd4);
                check("bb_r", 32'(r), 32'd2);
            end
        end
        start = 1'b0;
        check("bb_pulses", 32'(pulses), 32'd3);
        @(negedge clk);

        // asynchronous reset between clock edges mid-RUN
        @(negedge clk);
        x = 4'd11; y = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_q", 32'(q), 32'd0);
        check("arst_r", 32'(r), 32'd0);
        check("arst_dz", 32'(dz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd11, 4'd2, 5, 1, 0, 4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
